parity_frame_arbiter: RTL and testbench
=======================================

# parity_frame_arbiter

- Shares one even-parity generator and one serial transmit line between two 4-bit message requesters.
- Arbitrates round-robin and latches the granted nibble with its even parity bit, P = D3^D2^D1^D0.
- Shifts out a 7-bit frame: start, 4 data bits LSB first, parity, stop.
- Sits between the message sources and the serial link, in place of a free-running combinational parity generator.

## Interface

Parameters:
- BIT_CYCLES, default 4: clock cycles each serial bit is held. Legal range is 1 to 255.

Ports:
- CLK, input, 1: the single clock. All state updates on the rising edge.
- RST_N, input, 1: synchronous, active-low reset, sampled on the CLK rising edge.
- REQ0, input, 1: requester 0 has a message. Held high until granted.
- DAT0, input, 4: requester 0 message. Must be stable while REQ0 is high.
- REQ1, input, 1: requester 1 has a message. Same rules as REQ0.
- DAT1, input, 4: requester 1 message. Same rules as DAT0.
- GNT0, output, 1: one-cycle accept pulse for requester 0. DAT0 is captured at the edge ending this cycle.
- GNT1, output, 1: same as GNT0, for requester 1.
- TXD, output, 1: registered serial output. Idle level is 1.
- BUSY, output, 1: high while a frame is in flight, START through STOP.
- SRC, output, 1: index of the requester whose frame is in flight or was last sent.
- PAR, output, 1: parity bit latched for the current or last frame.

## Operation

State machine states: IDLE, START, DATA, PARITY, STOP.

IDLE:
- TXD=1, BUSY=0.
- If any REQ is high, the arbiter selects one and asserts its GNT combinationally in that cycle.
- At the edge ending that cycle:
  - the shift register takes the selected DAT;
  - PAR takes the XOR of the four selected data bits;
  - SRC takes the selected index;
  - LAST takes the selected index;
  - state moves to START.

Arbitration:
- Only one REQ high: that requester wins.
- Both high: the requester not equal to LAST wins.
- LAST resets to 1, so REQ0 wins the first tie after reset.
- GNT0 and GNT1 are never high together, and are 0 outside IDLE.

Frame states:
- START: TXD=0.
- DATA: TXD = shift register bit 0; the register shifts right after each bit period; 4 bit periods, counted by a 2-bit counter.
- PARITY: TXD=PAR.
- STOP: TXD=1, then return to IDLE.

Counting:
- Each bit period is exactly BIT_CYCLES cycles, counted by a cycle counter of width ceil(log2(BIT_CYCLES+1)).
- The cycle counter reloads to 0 on every state or bit change and never wraps mid-bit.

Requester behaviour:
- A REQ arriving mid-frame waits; it is evaluated in the next IDLE cycle.
- A requester may keep REQ high to send consecutive frames.
- GNT never fires outside IDLE.

## Timing

- Grant-to-start: GNT high in IDLE cycle t. TXD=0 and BUSY=1 from cycle t+1.
- Frame length: 7*BIT_CYCLES cycles. The last STOP cycle is t+7*BIT_CYCLES.
- Back-to-back frames: exactly one IDLE cycle (TXD=1) between the last STOP cycle and the next START. Minimum grant spacing is 7*BIT_CYCLES+1 cycles.
- GNT is a combinational function of registered state and REQ. TXD, BUSY, SRC and PAR are registered.
- Reset values, one cycle after RST_N is sampled low: state=IDLE, TXD=1, BUSY=0, SRC=0, PAR=0, LAST=1, counters=0.
- GNT0 and GNT1 are forced 0 while RST_N is low.
- Reset mid-frame aborts the frame immediately with no completion. That requester must re-request.
- If RST_N is low in a cycle where GNT would otherwise fire, no capture occurs.

## Test plan

1. Single frame, BIT_CYCLES=4, REQ0=1, DAT0=4'b1011.
   - GNT0 high for 1 cycle.
   - TXD = 0,1,1,0,1,1,1, each bit for 4 cycles. PAR=1, SRC=0.
   - BUSY high for 28 cycles.
2. Parity extremes, BIT_CYCLES=1.
   - DAT0=4'h0: parity bit 0, TXD=0,0,0,0,0,0,1.
   - DAT0=4'hF: parity bit 0.
   - DAT0=4'h1: parity bit 1.
3. Tie after reset: REQ0 and REQ1 held high.
   - Grant order is GNT0, GNT1, GNT0, GNT1.
   - Grants are spaced 7*BIT_CYCLES+1 cycles apart.
   - SRC alternates to match.
4. Late arrival and hold-high:
   - REQ1 rises during REQ0's DATA state: no GNT1 until the next IDLE cycle. That frame carries DAT1 with SRC=1.
   - REQ0 held high alone: repeated frames, each separated by one IDLE cycle.
5. Reset mid-DATA: drop RST_N during the second data bit.
   - Next cycle: TXD=1, BUSY=0, SRC=0, PAR=0.
   - With REQ0 and REQ1 both high, the first post-reset grant is GNT0.
6. BIT_CYCLES=1 with both requesters continuously active:
   - Every frame is 7 cycles, followed by 1 IDLE cycle.
   - No GNT outside IDLE. GNT0 and GNT1 never high together.

Source files
------------

// File: rtl/parity_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : parity_frame_arbiter
//  Description : Round-robin arbiter sharing one even-parity generator and one
//                serial transmit line between two 4-bit requesters. The
//                granted nibble is framed as start, 4 data bits (LSB first),
//                even parity and stop, each bit held for BIT_CYCLES clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_arbiter #(
    parameter int BIT_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ0,
    input  logic [3:0] DAT0,
    input  logic       REQ1,
    input  logic [3:0] DAT1,
    output logic       GNT0,
    output logic       GNT1,
    output logic       TXD,
    output logic       BUSY,
    output logic       SRC,
    output logic       PAR
);

    // Cycle counter must hold 0 .. BIT_CYCLES-1 without wrapping.
    localparam int              c_cnt_w    = $clog2(BIT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cyc;
    logic [1:0]           r_bit;
    logic [3:0]           r_shift;
    logic                 r_par;
    logic                 r_src;
    logic                 r_last;
    logic                 r_txd;
    logic                 r_busy;

    logic                 w_any;
    logic                 w_sel;
    logic [3:0]           w_dat;
    logic                 w_bit_end;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    // Grants only exist in IDLE and are suppressed while reset is asserted.
    always_comb begin
        w_any = (r_state == S_IDLE) && RST_N && (REQ0 || REQ1);
        if (REQ0 && REQ1) begin
            w_sel = ~r_last;
        end else begin
            w_sel = REQ1;
        end
        w_dat     = w_sel ? DAT1 : DAT0;
        w_bit_end = (r_cyc == c_bit_last);
    end

    assign GNT0 = w_any & ~w_sel;
    assign GNT1 = w_any &  w_sel;

    // Frame sequencer: captures the granted nibble and drives the registered
    // serial line; TXD is loaded with the level of the state being entered.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_src   <= 1'b0;
            r_last  <= 1'b1;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_shift <= w_dat;
                        r_par   <= ^w_dat;
                        r_src   <= w_sel;
                        r_last  <= w_sel;
                        r_cyc   <= '0;
                        r_bit   <= '0;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cyc   <= '0;
                        r_txd   <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cyc <= '0;
                        if (r_bit == 2'd3) begin
                            r_bit   <= '0;
                            r_txd   <= r_par;
                            r_state <= S_PARITY;
                        end else begin
                            // Next bit is shift[1]; present it as the register shifts.
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {1'b0, r_shift[3:1]};
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cyc   <= '0;
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cyc   <= '0;
                        r_txd   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                default: begin
                    r_cyc   <= '0;
                    r_bit   <= '0;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign TXD  = r_txd;
    assign BUSY = r_busy;
    assign SRC  = r_src;
    assign PAR  = r_par;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_frame_arbiter
//  Description : Bench for parity_frame_arbiter. Instance A runs with
//                BIT_CYCLES=4, instance B with BIT_CYCLES=1. Expected frames
//                are queued as grants are expected and a frame monitor per
//                instance pops and compares each transmitted frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_arbiter;

    localparam int BC_A = 4;
    localparam int BC_B = 1;

    typedef struct packed {
        logic       src;
        logic [3:0] dat;
    } exp_t;

    logic            clk = 1'b0;
    logic [1:0]      rst_n;
    logic [1:0]      req0;
    logic [1:0]      req1;
    logic [1:0][3:0] dat0;
    logic [1:0][3:0] dat1;
    logic [1:0]      skip;

    wire a_gnt0, a_gnt1, a_txd, a_busy, a_src, a_par;
    wire b_gnt0, b_gnt1, b_txd, b_busy, b_src, b_par;
    wire [1:0] gnt0 = {b_gnt0, a_gnt0};
    wire [1:0] gnt1 = {b_gnt1, a_gnt1};
    wire [1:0] txd  = {b_txd,  a_txd};
    wire [1:0] busy = {b_busy, a_busy};
    wire [1:0] src  = {b_src,  a_src};
    wire [1:0] par  = {b_par,  a_par};

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   viol = 0;
    int   cyc = 0;

    parity_frame_arbiter #(.BIT_CYCLES(BC_A)) u_dut_a (
        .CLK(clk), .RST_N(rst_n[0]),
        .REQ0(req0[0]), .DAT0(dat0[0]), .REQ1(req1[0]), .DAT1(dat1[0]),
        .GNT0(a_gnt0), .GNT1(a_gnt1), .TXD(a_txd), .BUSY(a_busy),
        .SRC(a_src), .PAR(a_par)
    );

    parity_frame_arbiter #(.BIT_CYCLES(BC_B)) u_dut_b (
        .CLK(clk), .RST_N(rst_n[1]),
        .REQ0(req0[1]), .DAT0(dat0[1]), .REQ1(req1[1]), .DAT1(dat1[1]),
        .GNT0(b_gnt0), .GNT1(b_gnt1), .TXD(b_txd), .BUSY(b_busy),
        .SRC(b_src), .PAR(b_par)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Grants must be exclusive and never appear while a frame is in flight.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if ((gnt0[g] && gnt1[g]) || ((gnt0[g] || gnt1[g]) && busy[g] === 1'b1))
                viol = viol + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int g, input int limit, output int which, output int t);
        which = -1;
        t     = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (gnt0[g] === 1'b1 || gnt1[g] === 1'b1) begin
                which = (gnt1[g] === 1'b1) ? 1 : 0;
                t     = cyc;
                return;
            end
        end
    endtask

    task automatic wait_idle(input int g, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busy[g] === 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Frame monitor: pops the expected frame at BUSY rise, samples each bit
    // period, and compares pattern, stability and length at BUSY fall.
    task automatic run_monitor(input int g, input int bc);
        logic       prev_busy = 1'b0;
        bit         active = 1'b0;
        bit         ign = 1'b0;
        bit         stable = 1'b1;
        int         k = 0;
        exp_t       e;
        logic [6:0] expb = '0;
        logic [6:0] obs = '0;
        forever begin
            @(negedge clk);
            if (busy[g] === 1'b1 && prev_busy !== 1'b1) begin
                active = 1'b1;
                k      = 0;
                stable = 1'b1;
                obs    = '0;
                ign    = skip[g];
                if (!ign) begin
                    n_total++;
                    if ((g == 0 && q_a.size() == 0) || (g == 1 && q_b.size() == 0)) begin
                        $display("FAIL frame_expected dut%0d: frame started at cycle %0d, none required", g, cyc);
                        ign = 1'b1;
                    end else begin
                        n_pass++;
                        if (g == 0) e = q_a.pop_front();
                        else        e = q_b.pop_front();
                        expb = {1'b1, ^e.dat, e.dat, 1'b0};
                        n_total++;
                        if ({src[g], par[g]} !== {e.src, ^e.dat})
                            $display("FAIL frame_src_par dut%0d: got src=%b par=%b need src=%b par=%b",
                                     g, src[g], par[g], e.src, ^e.dat);
                        else
                            n_pass++;
                    end
                end
            end
            if (active && busy[g] === 1'b1) begin
                if (k < 7 * bc) begin
                    if (k % bc == 0) obs[k / bc] = txd[g];
                    else if (txd[g] !== obs[k / bc]) stable = 1'b0;
                end else begin
                    stable = 1'b0;
                end
                k++;
            end
            if (active && busy[g] === 1'b0) begin
                active = 1'b0;
                if (!ign) begin
                    n_total++;
                    if (obs !== expb || !stable || k != 7 * bc)
                        $display("FAIL frame_txd dut%0d: got bits=%b stable=%0d len=%0d need bits=%b stable=1 len=%0d",
                                 g, obs, stable, k, expb, 7 * bc);
                    else
                        n_pass++;
                end
            end
            prev_busy = busy[g];
        end
    endtask

    initial run_monitor(0, BC_A);
    initial run_monitor(1, BC_B);

    task automatic test_reset();
        rst_n = 2'b00;
        req0  = 2'b11;
        req1  = 2'b11;
        step();
        step();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            n_total++;
            if ({txd[g], busy[g], src[g], par[g], gnt0[g], gnt1[g]} !== 6'b100000)
                $display("FAIL reset_state dut%0d: got txd,busy,src,par,gnt0,gnt1=%b need 100000",
                         g, {txd[g], busy[g], src[g], par[g], gnt0[g], gnt1[g]});
            else
                n_pass++;
        end
        step();
        req0  = 2'b00;
        req1  = 2'b00;
        rst_n = 2'b11;
    endtask

    task automatic test_single_frame();
        int which, t;
        bit ok;
        step();
        dat0[0] = 4'b1011;
        req0[0] = 1'b1;
        wait_grant(0, 5, which, t);
        n_total++;
        if (which !== 0) $display("FAIL single_grant: got %0d need 0", which);
        else n_pass++;
        q_a.push_back('{src: 1'b0, dat: 4'b1011});
        step();
        req0[0] = 1'b0;
        @(negedge clk);
        n_total++;
        if ({gnt0[0], gnt1[0], txd[0], busy[0], src[0], par[0]} !== 6'b000101)
            $display("FAIL single_start: got gnt0,gnt1,txd,busy,src,par=%b need 000101",
                     {gnt0[0], gnt1[0], txd[0], busy[0], src[0], par[0]});
        else
            n_pass++;
        wait_idle(0, 40, ok);
        n_total++;
        if (!ok) $display("FAIL single_idle: got busy=%b need 0", busy[0]);
        else n_pass++;
    endtask

    task automatic test_parity_extremes();
        logic [3:0] vals [3];
        logic       pexp [3];
        int         which, t;
        bit         ok;
        vals[0] = 4'h0; pexp[0] = 1'b0;
        vals[1] = 4'hF; pexp[1] = 1'b0;
        vals[2] = 4'h1; pexp[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            dat0[1] = vals[i];
            req0[1] = 1'b1;
            wait_grant(1, 5, which, t);
            n_total++;
            if (which !== 0) $display("FAIL parity_grant %0d: got %0d need 0", i, which);
            else n_pass++;
            q_b.push_back('{src: 1'b0, dat: vals[i]});
            step();
            req0[1] = 1'b0;
            @(negedge clk);
            n_total++;
            if ({par[1], busy[1], txd[1]} !== {pexp[i], 2'b10})
                $display("FAIL parity_bit %0d: got par,busy,txd=%b need %b", i,
                         {par[1], busy[1], txd[1]}, {pexp[i], 2'b10});
            else
                n_pass++;
            wait_idle(1, 20, ok);
            n_total++;
            if (!ok) $display("FAIL parity_idle %0d: got busy=%b need 0", i, busy[1]);
            else n_pass++;
        end
    endtask

    task automatic test_tie();
        int which, t, tprev, exp_w;
        bit ok;
        tprev = 0;
        step();
        rst_n[0] = 1'b0;
        step();
        rst_n[0] = 1'b1;
        dat0[0]  = 4'h5;
        dat1[0]  = 4'hA;
        req0[0]  = 1'b1;
        req1[0]  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_w = i % 2;
            wait_grant(0, 40, which, t);
            n_total++;
            if (which !== exp_w || (i > 0 && t - tprev != 7 * BC_A + 1))
                $display("FAIL tie_grant %0d: got gnt%0d spacing %0d need gnt%0d spacing %0d",
                         i, which, t - tprev, exp_w, 7 * BC_A + 1);
            else
                n_pass++;
            q_a.push_back('{src: exp_w[0], dat: (exp_w == 1) ? 4'hA : 4'h5});
            tprev = t;
            step();
            if (i == 3) begin
                req0[0] = 1'b0;
                req1[0] = 1'b0;
            end
            @(negedge clk);
            n_total++;
            if (src[0] !== exp_w[0]) $display("FAIL tie_src %0d: got %b need %b", i, src[0], exp_w[0]);
            else n_pass++;
        end
        wait_idle(0, 40, ok);
        n_total++;
        if (!ok) $display("FAIL tie_idle: got busy=%b need 0", busy[0]);
        else n_pass++;
    endtask

    task automatic test_late_arrival();
        int which, t, t0;
        bit ok;
        step();
        dat0[0] = 4'h3;
        req0[0] = 1'b1;
        wait_grant(0, 5, which, t0);
        n_total++;
        if (which !== 0) $display("FAIL late_first: got %0d need 0", which);
        else n_pass++;
        q_a.push_back('{src: 1'b0, dat: 4'h3});
        step();
        req0[0] = 1'b0;
        repeat (7) step();
        dat1[0] = 4'hC;
        req1[0] = 1'b1;
        wait_grant(0, 40, which, t);
        n_total++;
        if (which !== 1 || t - t0 != 7 * BC_A + 1)
            $display("FAIL late_gnt1: got gnt%0d after %0d cycles need gnt1 after %0d",
                     which, t - t0, 7 * BC_A + 1);
        else
            n_pass++;
        q_a.push_back('{src: 1'b1, dat: 4'hC});
        step();
        req1[0] = 1'b0;
        dat0[0] = 4'h6;
        req0[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t0 = t;
            wait_grant(0, 40, which, t);
            n_total++;
            if (which !== 0 || t - t0 != 7 * BC_A + 1)
                $display("FAIL hold_grant %0d: got gnt%0d spacing %0d need gnt0 spacing %0d",
                         i, which, t - t0, 7 * BC_A + 1);
            else
                n_pass++;
            q_a.push_back('{src: 1'b0, dat: 4'h6});
            step();
            if (i == 2) req0[0] = 1'b0;
        end
        wait_idle(0, 40, ok);
        n_total++;
        if (!ok) $display("FAIL hold_idle: got busy=%b need 0", busy[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_data();
        int which, t;
        bit ok;
        skip[0] = 1'b1;
        step();
        dat1[0] = 4'b0111;
        req1[0] = 1'b1;
        wait_grant(0, 5, which, t);
        n_total++;
        if (which !== 1) $display("FAIL abort_grant: got %0d need 1", which);
        else n_pass++;
        step();
        req1[0] = 1'b0;
        repeat (8) step();
        rst_n[0] = 1'b0;
        dat0[0]  = 4'hE;
        req0[0]  = 1'b1;
        req1[0]  = 1'b1;
        @(negedge clk);
        n_total++;
        if ({txd[0], busy[0], src[0], par[0]} !== 4'b1111)
            $display("FAIL abort_pre: got txd,busy,src,par=%b need 1111",
                     {txd[0], busy[0], src[0], par[0]});
        else
            n_pass++;
        step();
        @(negedge clk);
        n_total++;
        if ({txd[0], busy[0], src[0], par[0], gnt0[0], gnt1[0]} !== 6'b100000)
            $display("FAIL abort_reset: got txd,busy,src,par,gnt0,gnt1=%b need 100000",
                     {txd[0], busy[0], src[0], par[0], gnt0[0], gnt1[0]});
        else
            n_pass++;
        step();
        rst_n[0] = 1'b1;
        skip[0]  = 1'b0;
        @(negedge clk);
        n_total++;
        if ({gnt0[0], gnt1[0]} !== 2'b10)
            $display("FAIL abort_regrant: got gnt0,gnt1=%b need 10", {gnt0[0], gnt1[0]});
        else
            n_pass++;
        q_a.push_back('{src: 1'b0, dat: 4'hE});
        step();
        req0[0] = 1'b0;
        req1[0] = 1'b0;
        wait_idle(0, 40, ok);
        n_total++;
        if (!ok) $display("FAIL abort_idle: got busy=%b need 0", busy[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int which, t, tprev, exp_w;
        bit ok;
        tprev = 0;
        step();
        rst_n[1] = 1'b0;
        step();
        rst_n[1] = 1'b1;
        dat0[1]  = 4'h2;
        dat1[1]  = 4'hD;
        req0[1]  = 1'b1;
        req1[1]  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_w = i % 2;
            wait_grant(1, 12, which, t);
            n_total++;
            if (which !== exp_w || (i > 0 && t - tprev != 7 * BC_B + 1))
                $display("FAIL b2b_grant %0d: got gnt%0d spacing %0d need gnt%0d spacing %0d",
                         i, which, t - tprev, exp_w, 7 * BC_B + 1);
            else
                n_pass++;
            q_b.push_back('{src: exp_w[0], dat: (exp_w == 1) ? 4'hD : 4'h2});
            tprev = t;
            step();
            if (i == 7) begin
                req0[1] = 1'b0;
                req1[1] = 1'b0;
            end
        end
        wait_idle(1, 20, ok);
        n_total++;
        if (!ok) $display("FAIL b2b_idle: got busy=%b need 0", busy[1]);
        else n_pass++;
        n_total++;
        if (viol != 0) $display("FAIL grant_rules: got %0d violations need 0", viol);
        else n_pass++;
    endtask

    initial begin
        rst_n = 2'b00;
        req0  = 2'b00;
        req1  = 2'b00;
        dat0  = '0;
        dat1  = '0;
        skip  = 2'b00;
        test_reset();
        test_single_frame();
        test_parity_extremes();
        test_tie();
        test_late_arrival();
        test_reset_mid_data();
        test_back_to_back();
        repeat (3) step();
        n_total++;
        if (q_a.size() + q_b.size() != 0)
            $display("FAIL frames_outstanding: got %0d need 0", q_a.size() + q_b.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
